approx_adder_evaluator: RTL and testbench

- Synthesizable on-chip stimulus generator and error checker for approximate (CGP-evolved) adders.
- Drives every operand pair {a,b} into an external adder under test and reads its sum back after a fixed latency.
- Compares each returned sum against the exact modulo-2^WIDTH sum and accumulates total absolute error, worst-case error (WCE) and mean absolute error (MAE).
- Sits on the far side of the adder from the host as its active driver/checker, giving hardware sign-off of approximate circuits on FPGA.

---
 rtl/approx_adder_evaluator.sv | 208 ++++++++++++++++++++
 tb/tb_approx_adder_evaluator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_evaluator.sv
// approx_adder_evaluator
// Drives every {a,b} operand pair into an external approximate adder and
// checks the sum it returns against the exact modulo-2^WIDTH sum. It keeps
// the total absolute error, the worst-case error and the mean absolute error.
// The returned sum is paired with its exact sum through a DUT_LATENCY-deep
// shift register. With DUT_LATENCY=0 the adder is taken to be combinational.
module approx_adder_evaluator #(
  parameter int WIDTH       = 8,
  parameter int DUT_LATENCY = 0,
  parameter int WCE_LIMIT   = 50,
  parameter int MAE_LIMIT   = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     sum,
  output logic                 busy,
  output logic                 done,
  output logic [3*WIDTH-1:0]   error_total,
  output logic [WIDTH-1:0]     wce,
  output logic [WIDTH-1:0]     mae,
  output logic                 pass
);

  localparam int IW    = 2 * WIDTH;
  localparam int EW    = 3 * WIDTH;
  localparam int LAT_D = (DUT_LATENCY > 0) ? DUT_LATENCY : 1;
  localparam int CW    = (LAT_D > 1) ? $clog2(LAT_D) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IW-1:0] IDX_LAST   = {IW{1'b1}};
  localparam logic [CW-1:0] DRAIN_LAST = CW'(LAT_D - 1);

  logic [1:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_drain_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [EW-1:0]    r_err;
  logic [WIDTH-1:0] r_wce;
  logic [WIDTH-1:0] r_mae;

  logic             w_start_acc;
  logic             w_vld_now;
  logic             w_vld;
  logic             w_pass_upd;
  logic [WIDTH-1:0] w_exact_now;
  logic [WIDTH-1:0] w_exp;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_wce_upd;
  logic [WIDTH-1:0] w_mae_upd;
  logic [EW-1:0]    w_err_upd;

  // start is only honoured when no run is in progress.
  assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // The vector counter is the operand register: a is the upper half, b the lower half.
  assign w_exact_now = r_idx[IW-1:WIDTH] + r_idx[WIDTH-1:0];
  assign w_vld_now   = (r_state == S_RUN);

  generate
    if (DUT_LATENCY == 0) begin : g_nodelay
      assign w_exp = w_exact_now;
      assign w_vld = w_vld_now;
    end else begin : g_delay
      logic [WIDTH-1:0]       r_pipe_exp [DUT_LATENCY];
      logic [DUT_LATENCY-1:0] r_pipe_vld;

      // Delay the exact sum and its valid flag so they meet the adder's sum.
      always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
          for (int i = 0; i < DUT_LATENCY; i++) begin
            r_pipe_exp[i] <= '0;
          end
          r_pipe_vld <= '0;
        end else begin
          r_pipe_exp[0] <= w_exact_now;
          r_pipe_vld[0] <= w_vld_now;
          for (int i = 1; i < DUT_LATENCY; i++) begin
            r_pipe_exp[i] <= r_pipe_exp[i-1];
            r_pipe_vld[i] <= r_pipe_vld[i-1];
          end
        end
      end

      assign w_exp = r_pipe_exp[DUT_LATENCY-1];
      assign w_vld = r_pipe_vld[DUT_LATENCY-1];
    end
  endgenerate

  // Absolute difference between the exact sum and the returned sum (both unsigned).
  always_comb begin
    w_diff = '0;
    if (w_exp >= sum) begin
      w_diff = w_exp - sum;
    end else begin
      w_diff = sum - w_exp;
    end
  end

  // Next accumulator values. These are used on the cycle a valid pair arrives.
  always_comb begin
    w_err_upd = r_err;
    w_wce_upd = r_wce;
    if (w_vld) begin
      w_err_upd = r_err + EW'(w_diff);
      if (w_diff > r_wce) begin
        w_wce_upd = w_diff;
      end else begin
        w_wce_upd = r_wce;
      end
    end else begin
      w_err_upd = r_err;
      w_wce_upd = r_wce;
    end
  end

  // The mean is the total divided by the 2^(2*WIDTH) vectors.
  assign w_mae_upd  = w_err_upd[EW-1:IW];
  assign w_pass_upd = (32'(w_mae_upd) <= MAE_LIMIT) &&
                      (32'(w_wce_upd) <= WCE_LIMIT) &&
                      (w_wce_upd != '0);

  // Control FSM, stimulus counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= '0;
      r_wce       <= '0;
      r_mae       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_idx       <= '0;
            r_drain_cnt <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= '0;
            r_wce       <= '0;
            r_mae       <= '0;
          end
        end
        S_RUN: begin
          r_err <= w_err_upd;
          r_wce <= w_wce_upd;
          r_mae <= w_mae_upd;
          if (r_idx == IDX_LAST) begin
            if (DUT_LATENCY == 0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= w_pass_upd;
            end else begin
              r_state     <= S_DRAIN;
              r_drain_cnt <= '0;
            end
          end else begin
            r_idx <= r_idx + {{(IW-1){1'b0}}, 1'b1};
          end
        end
        S_DRAIN: begin
          r_err <= w_err_upd;
          r_wce <= w_wce_upd;
          r_mae <= w_mae_upd;
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= w_pass_upd;
          end else begin
            r_drain_cnt <= r_drain_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign a           = r_idx[IW-1:WIDTH];
  assign b           = r_idx[WIDTH-1:0];
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign error_total = r_err;
  assign wce         = r_wce;
  assign mae         = r_mae;

endmodule

// File: tb/tb_approx_adder_evaluator.sv
// Bench for approx_adder_evaluator. There are two WIDTH=4 instances. The first
// has a combinational adder and the default limits. The second has an adder
// registered twice (latency 2) and tight limits. Each run's results are
// compared with an exhaustive arithmetic model of the adder under test.
module tb_approx_adder_evaluator;

  localparam int WCE_L2 = 7;
  localparam int MAE_L2 = 3;

  logic clk = 1'b0;
  logic rst;
  logic start;

  always #5 clk = ~clk;

  logic [3:0]  a0, b0, s0, wce0, mae0;
  logic [3:0]  a2, b2, s2, wce2, mae2;
  logic [11:0] et0, et2;
  logic        busy0, done0, pass0, busy2, done2, pass2;

  int               mode;
  logic [255:0][3:0] lut;
  logic [3:0]       s2_r1, s2_r2;

  int checks = 0;
  int errors = 0;

  // Adder under test: 0 exact, 1 drop bit 0, 2 stuck at 0, otherwise lookup table.
  function automatic logic [3:0] sum_model(input int m, input logic [3:0] x,
                                           input logic [3:0] y, input logic [255:0][3:0] t);
    logic [3:0] ex;
    logic [7:0] k;
    ex = x + y;
    k  = {x, y};
    case (m)
      0:       return ex;
      1:       return ex & 4'hE;
      2:       return 4'h0;
      default: return t[k];
    endcase
  endfunction

  assign s0 = sum_model(mode, a0, b0, lut);

  always @(posedge clk) begin
    s2_r1 <= sum_model(mode, a2, b2, lut);
    s2_r2 <= s2_r1;
  end
  assign s2 = s2_r2;

  approx_adder_evaluator #(.WIDTH(4), .DUT_LATENCY(0), .WCE_LIMIT(50), .MAE_LIMIT(50)) u_l0 (
    .clk(clk), .rst(rst), .start(start), .a(a0), .b(b0), .sum(s0), .busy(busy0),
    .done(done0), .error_total(et0), .wce(wce0), .mae(mae0), .pass(pass0));

  approx_adder_evaluator #(.WIDTH(4), .DUT_LATENCY(2), .WCE_LIMIT(WCE_L2), .MAE_LIMIT(MAE_L2)) u_l2 (
    .clk(clk), .rst(rst), .start(start), .a(a2), .b(b2), .sum(s2), .busy(busy2),
    .done(done2), .error_total(et2), .wce(wce2), .mae(mae2), .pass(pass2));

  logic [11:0] et_a   [2];
  logic [3:0]  wce_a  [2];
  logic [3:0]  mae_a  [2];
  logic        pass_a [2];
  logic        busy_a [2];
  logic        done_a [2];
  assign et_a[0]   = et0;   assign et_a[1]   = et2;
  assign wce_a[0]  = wce0;  assign wce_a[1]  = wce2;
  assign mae_a[0]  = mae0;  assign mae_a[1]  = mae2;
  assign pass_a[0] = pass0; assign pass_a[1] = pass2;
  assign busy_a[0] = busy0; assign busy_a[1] = busy2;
  assign done_a[0] = done0; assign done_a[1] = done2;

  // Reference: sweep every operand pair with plain integer arithmetic.
  task automatic ref_model(output int e, output int w);
    int ex, ap, d;
    e = 0;
    w = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        ex = (x + y) % 16;
        ap = int'(sum_model(mode, 4'(x), 4'(y), lut));
        d  = (ex > ap) ? ex - ap : ap - ex;
        e += d;
        if (d > w) w = d;
      end
    end
  endtask

  task automatic gen_lut(input int pct);
    int ex;
    for (int i = 0; i < 256; i++) begin
      ex = ((i >> 4) + (i & 15)) % 16;
      if ($urandom_range(99, 0) < pct) lut[i] = 4'($urandom);
      else                             lut[i] = 4'(ex);
    end
  endtask

  // Pulse start and measure when each instance first reports done. Cycle 0 is
  // the start cycle. A second start pulse can be placed at cycle extra_at.
  task automatic do_run(input int extra_at, output int d0, output int d2, output bit ok1);
    d0  = -1;
    d2  = -1;
    ok1 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      start = (n == extra_at);
      if (n == 1) ok1 = busy0 && busy2 && !done0 && !done2 && !pass0 && !pass2;
      if (done0 && d0 < 0) d0 = n;
      if (done2 && d2 < 0) d2 = n;
      if (d0 >= 0 && d2 >= 0) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    lut   = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy_a[d], done_a[d], pass_a[d]} !== 3'b000 || et_a[d] !== 12'd0 ||
          wce_a[d] !== 4'd0 || mae_a[d] !== 4'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got busy=%b done=%b pass=%b err=%0d wce=%0d mae=%0d want all 0",
                 d, busy_a[d], done_a[d], pass_a[d], et_a[d], wce_a[d], mae_a[d]);
      end
    end
    checks++;
    if ({a0, b0, a2, b2} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_operands got a0=%0d b0=%0d a2=%0d b2=%0d want 0", a0, b0, a2, b2);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Each run checks timing, the start it ignores at cycle 50, and the results.
  task automatic test_error_modes;
    int e, w, d0, d2, dc, wl, ml;
    bit ok1, xp;
    int modes [6] = '{0, 1, 2, 3, 3, 3};
    int pcts  [6] = '{0, 0, 0, 10, 40, 100};
    for (int s = 0; s < 6; s++) begin
      mode = modes[s];
      if (mode == 3) gen_lut(pcts[s]);
      ref_model(e, w);
      do_run(50, d0, d2, ok1);
      checks++;
      if (!ok1) begin
        errors++;
        $display("FAIL run_first_cycle mode%0d got busy=%b/%b done=%b/%b want busy=1 done=0",
                 mode, busy0, busy2, done0, done2);
      end
      for (int d = 0; d < 2; d++) begin
        dc = d ? d2 : d0;
        wl = d ? WCE_L2 : 50;
        ml = d ? MAE_L2 : 50;
        xp = ((e >> 8) <= ml) && (w <= wl) && (w > 0);
        checks++;
        if (dc !== (d ? 259 : 257)) begin
          errors++;
          $display("FAIL done_cycle dut%0d mode%0d got %0d want %0d", d, mode, dc, d ? 259 : 257);
        end
        checks++;
        if (et_a[d] !== 12'(e) || wce_a[d] !== 4'(w) || mae_a[d] !== 4'(e >> 8)) begin
          errors++;
          $display("FAIL results dut%0d mode%0d got err=%0d wce=%0d mae=%0d want err=%0d wce=%0d mae=%0d",
                   d, mode, et_a[d], wce_a[d], mae_a[d], e, w, e >> 8);
        end
        checks++;
        if (pass_a[d] !== xp || busy_a[d] !== 1'b0) begin
          errors++;
          $display("FAIL pass_busy dut%0d mode%0d got pass=%b busy=%b want pass=%b busy=0",
                   d, mode, pass_a[d], busy_a[d], xp);
        end
      end
    end
  endtask

  // A restart while in DONE must clear done at once and repeat the same results.
  task automatic test_back_to_back;
    int e, w, d0, d2;
    bit ok1;
    mode = 1;
    ref_model(e, w);
    for (int r = 0; r < 2; r++) begin
      do_run(0, d0, d2, ok1);
      checks++;
      if (!ok1 || d0 !== 257 || d2 !== 259) begin
        errors++;
        $display("FAIL b2b_timing run%0d got first_ok=%b done0=%0d done2=%0d want 1 257 259", r, ok1, d0, d2);
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (et_a[d] !== 12'(e) || wce_a[d] !== 4'(w) || mae_a[d] !== 4'd0 || pass_a[d] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_results dut%0d run%0d got err=%0d wce=%0d mae=%0d pass=%b want %0d %0d 0 1",
                   d, r, et_a[d], wce_a[d], mae_a[d], pass_a[d], e, w);
        end
      end
    end
  endtask

  // Reset in the middle of a run, then start and rst together, then a clean run.
  task automatic test_reset_midrun;
    int e, w, d0, d2;
    bit ok1;
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b1 || et0 === 12'd0) begin
      errors++;
      $display("FAIL midrun_active got busy=%b err=%0d want busy=1 err>0", busy0, et0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy_a[d], done_a[d], pass_a[d]} !== 3'b000 || et_a[d] !== 12'd0 ||
          wce_a[d] !== 4'd0 || mae_a[d] !== 4'd0) begin
        errors++;
        $display("FAIL midrun_reset dut%0d got busy=%b done=%b err=%0d wce=%0d mae=%0d want all 0",
                 d, busy_a[d], done_a[d], et_a[d], wce_a[d], mae_a[d]);
      end
    end
    checks++;
    if ({a0, b0, a2, b2} !== 16'h0000) begin
      errors++;
      $display("FAIL midrun_operands got a0=%0d b0=%0d want 0", a0, b0);
    end
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b0 || busy2 !== 1'b0 || a0 !== 4'd0 || b0 !== 4'd1 - 4'd1) begin
      errors++;
      $display("FAIL rst_beats_start got busy0=%b busy2=%b a0=%0d b0=%0d want idle", busy0, busy2, a0, b0);
    end
    mode = 1;
    ref_model(e, w);
    do_run(0, d0, d2, ok1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (et_a[d] !== 12'(e) || wce_a[d] !== 4'(w) || pass_a[d] !== 1'b1 || (d ? d2 : d0) !== (d ? 259 : 257)) begin
        errors++;
        $display("FAIL after_reset_run dut%0d got err=%0d wce=%0d pass=%b done_cycle=%0d want %0d %0d 1 %0d",
                 d, et_a[d], wce_a[d], pass_a[d], d ? d2 : d0, e, w, d ? 259 : 257);
      end
    end
  endtask

  initial begin
    test_reset();
    test_error_modes();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
